// File: rtl/aq_dtu_cdc_pkg.sv
// Shared definitions for the DTU debug-event CDC arbiter: FSM encoding and
// default configuration constants.
package aq_dtu_cdc_pkg;

    typedef enum logic [1:0] {
        CDC_IDLE = 2'b00,
        CDC_REQ  = 2'b01,
        CDC_REL  = 2'b10
    } cdc_state_e;

    localparam int AQ_DTU_CDC_NUM_REQ_DEF = 4;
    localparam int AQ_DTU_CDC_TIMEOUT_DEF = 255;
    localparam int AQ_DTU_CDC_SYNC_STAGES = 3;

endpackage

// File: rtl/aq_dtu_cdc_ack_sync.sv
// Three-flop level synchronizer bringing the destination acknowledge into the
// source clock domain; all stages reset to 0.
module aq_dtu_cdc_ack_sync
    import aq_dtu_cdc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic ack_lvl_i,
    output logic ack_s_o
);

    logic [AQ_DTU_CDC_SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[AQ_DTU_CDC_SYNC_STAGES-2:0], ack_lvl_i};
        end
    end

    assign ack_s_o = sync_q[AQ_DTU_CDC_SYNC_STAGES-1];

endmodule

// File: rtl/aq_dtu_cdc_evt_arb.sv
// Round-robin arbiter sharing one 4-phase req/ack level CDC channel among
// NUM_REQ event sources. Optional ack timeout: define AQ_DTU_CDC_TIMEOUT_EN.
module aq_dtu_cdc_evt_arb
    import aq_dtu_cdc_pkg::*;
#(
    parameter int NUM_REQ     = AQ_DTU_CDC_NUM_REQ_DEF,
    parameter int ID_W        = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC = AQ_DTU_CDC_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] evt_req,
    output logic [NUM_REQ-1:0] evt_ovf,
    output logic               cdc_req_lvl,
    output logic [ID_W-1:0]    cdc_id,
    input  logic               cdc_ack_lvl,
    output logic               busy,
    output logic               evt_done,
    output logic [ID_W-1:0]    done_id,
    output logic               cdc_timeout
);

    // Rotate so the search starts just after the last grant, then take the
    // lowest set bit of the rotated vector.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] pend,
                                                input logic [ID_W-1:0]    last);
        logic [NUM_REQ-1:0] rot;
        logic [ID_W-1:0]    pick;
        logic               found;
        rot   = NUM_REQ'({pend, pend} >> (int'(last) + 1));
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pick  = ID_W'((int'(last) + 1 + k) % NUM_REQ);
            end
        end
        return pick;
    endfunction

    logic ack_s;

    aq_dtu_cdc_ack_sync u_ack_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .ack_lvl_i (cdc_ack_lvl),
        .ack_s_o   (ack_s)
    );

    cdc_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] clr;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               req_q, req_d;
    logic               done_q, done_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [ID_W-1:0]    sel;

`ifdef AQ_DTU_CDC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             aborted_q, aborted_d;
`endif

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        req_d     = req_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        clr       = '0;
        sel       = rr_pick(pending_q, last_q);
`ifdef AQ_DTU_CDC_TIMEOUT_EN
        tmo_d     = 1'b0;
        aborted_d = aborted_q;
        cnt_d     = (state_q == CDC_REQ) ? cnt_q + 1'b1 : '0;
`endif
        case (state_q)
            CDC_IDLE: begin
                if (|pending_q) begin
                    clr     = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
                    last_d  = sel;
                    id_d    = sel;
                    req_d   = 1'b1;
                    state_d = CDC_REQ;
                end
            end
            CDC_REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = CDC_REL;
                end
`ifdef AQ_DTU_CDC_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Abandon the event; REL still waits for a quiet ack line.
                    req_d     = 1'b0;
                    tmo_d     = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = CDC_REL;
                end
`endif
            end
            CDC_REL: begin
                if (!ack_s) begin
                    state_d = CDC_IDLE;
`ifdef AQ_DTU_CDC_TIMEOUT_EN
                    aborted_d = 1'b0;
                    if (!aborted_q) begin
                        done_d    = 1'b1;
                        done_id_d = id_q;
                    end
`else
                    done_d    = 1'b1;
                    done_id_d = id_q;
`endif
                end
            end
            default: state_d = CDC_IDLE;
        endcase
    end

    // A new pulse on the bit being granted re-arms it rather than merging.
    assign pending_d = (pending_q & ~clr) | evt_req;
    assign evt_ovf   = evt_req & pending_q & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CDC_IDLE;
            pending_q <= '0;
            last_q    <= ID_W'(NUM_REQ - 1);
            id_q      <= '0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            id_q      <= id_d;
            req_q     <= req_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

`ifdef AQ_DTU_CDC_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            aborted_q <= aborted_d;
        end
    end

    assign cdc_timeout = tmo_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
    assign cdc_timeout    = 1'b0;
`endif

    assign cdc_req_lvl = req_q;
    assign cdc_id      = id_q;
    assign busy        = (state_q != CDC_IDLE);
    assign evt_done    = done_q;
    assign done_id     = done_id_q;

endmodule

// File: tb/tb_aq_dtu_cdc_evt_arb.sv
// Scoreboard bench for aq_dtu_cdc_evt_arb with a destination-domain ack model.
module tb_aq_dtu_cdc_evt_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TMO     = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_REQ-1:0] evt_req;
    logic [NUM_REQ-1:0] evt_ovf;
    logic               cdc_req_lvl;
    logic [ID_W-1:0]    cdc_id;
    logic               cdc_ack_lvl;
    logic               busy;
    logic               evt_done;
    logic [ID_W-1:0]    done_id;
    logic               cdc_timeout;

    always #5 clk = ~clk;

    aq_dtu_cdc_evt_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .evt_req     (evt_req),
        .evt_ovf     (evt_ovf),
        .cdc_req_lvl (cdc_req_lvl),
        .cdc_id      (cdc_id),
        .cdc_ack_lvl (cdc_ack_lvl),
        .busy        (busy),
        .evt_done    (evt_done),
        .done_id     (done_id),
        .cdc_timeout (cdc_timeout)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model: pending set + round-robin ----------
    int           exp_id_q[$];
    int           exp_done_q[$];
    logic [3:0]   m_pend;
    int           m_last;
    int           ovf_cnt = 0;
    logic [3:0]   clr_m, oexp_m;
    int           g_m;

    function automatic int rr(input logic [3:0] p, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (last + k) % NUM_REQ;
            if (p[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_pend = '0;
            m_last = NUM_REQ - 1;
            exp_id_q.delete();
            exp_done_q.delete();
        end else begin
            clr_m = '0;
            if (!busy && m_pend != 0) begin
                g_m = rr(m_pend, m_last);
                exp_id_q.push_back(g_m);
                exp_done_q.push_back(g_m);
                m_last = g_m;
                clr_m[g_m] = 1'b1;
            end
            oexp_m = evt_req & m_pend & ~clr_m;
            if (evt_req != 0 || evt_ovf != 0) chk("evt_ovf", int'(evt_ovf), int'(oexp_m));
            ovf_cnt += $countones(evt_ovf);
            m_pend = (m_pend & ~clr_m) | evt_req;
        end
    end

    // ---------------- monitor ------------------------------------------------
    logic       prev_req = 1'b0;
    int         held_id  = 0;
    int         obs_ids[256];
    int         obs_n    = 0;
    int         done_n   = 0;
    int         tmo_n    = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
        end else begin
            if (cdc_req_lvl && !prev_req) begin
                if (exp_id_q.size() == 0) chk("grant_unexpected", 1, 0);
                else chk("grant_id", int'(cdc_id), exp_id_q.pop_front());
                held_id = cdc_id;
                obs_ids[obs_n % 256] = cdc_id;
                obs_n++;
            end else if (cdc_req_lvl) begin
                chk("cdc_id_stable", int'(cdc_id), held_id);
            end
            if (evt_done) begin
                if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_id", int'(done_id), exp_done_q.pop_front());
                done_n++;
            end
            if (cdc_timeout) tmo_n++;
            prev_req = cdc_req_lvl;
        end
    end

    // ---------------- destination-domain ack model ---------------------------
    logic dest_en = 1'b1;
    int   dmin    = 2;
    int   dmax    = 2;

    initial begin : dest
        int cnt;
        int dly;
        cnt = 0;
        dly = 2;
        cdc_ack_lvl = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !dest_en) begin
                cdc_ack_lvl = 1'b0;
                cnt = 0;
            end else if (cdc_ack_lvl == cdc_req_lvl) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= dly) begin
                    cdc_ack_lvl = cdc_req_lvl;
                    cnt = 0;
                    dly = $urandom_range(dmax, dmin);
                end
            end
        end
    end

    // ---------------- stimulus -----------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v);
        evt_req = v;
        tick();
        evt_req = '0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        evt_req = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        int stable;
        n = 0;
        stable = 0;
        while (stable < 4 && n < budget) begin
            tick();
            n++;
            if (!busy && m_pend == 0 && !cdc_ack_lvl) stable++;
            else stable = 0;
        end
        if (stable < 4) chk("wait_idle_timeout", 1, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int base, dbase, obase, n;

    initial begin
        rst_n   = 1'b0;
        evt_req = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cdc_req_lvl", int'(cdc_req_lvl), 0);
        chk("rst_cdc_id",      int'(cdc_id), 0);
        chk("rst_busy",        int'(busy), 0);
        chk("rst_evt_done",    int'(evt_done), 0);
        chk("rst_done_id",     int'(done_id), 0);
        chk("rst_evt_ovf",     int'(evt_ovf), 0);
        chk("rst_cdc_timeout", int'(cdc_timeout), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // single event: latency and one handshake
        base = obs_n; dbase = done_n;
        evt_req = 4'b0001;
        tick();
        evt_req = '0;
        chk("t1_req_after_1_edge", int'(cdc_req_lvl), 0);
        tick();
        chk("t1_req_after_2_edges", int'(cdc_req_lvl), 1);
        chk("t1_cdc_id", int'(cdc_id), 0);
        chk("t1_busy", int'(busy), 1);
        wait_idle(200);
        chk("t1_grants", obs_n - base, 1);
        chk("t1_done_count", done_n - dbase, 1);
        chk("t1_busy_after", int'(busy), 0);

        // all four at once after reset
        do_reset();
        base = obs_n; dbase = done_n; obase = ovf_cnt;
        pulse(4'b1111);
        wait_idle(400);
        chk("t2_grants", obs_n - base, 4);
        for (int i = 0; i < 4; i++) chk("t2_order", obs_ids[(base + i) % 256], i);
        chk("t2_done_count", done_n - dbase, 4);
        chk("t2_ovf", ovf_cnt - obase, 0);

        // merge on a pending bit while channel busy
        do_reset();
        dmin = 4; dmax = 4;
        base = obs_n; obase = ovf_cnt;
        pulse(4'b0010);
        tick();
        chk("t3_busy_id1", int'(busy), 1);
        pulse(4'b0100);
        tick();
        pulse(4'b0100);
        chk("t3_ovf_once", ovf_cnt - obase, 1);
        wait_idle(400);
        chk("t3_grants", obs_n - base, 2);
        chk("t3_first", obs_ids[base % 256], 1);
        chk("t3_second", obs_ids[(base + 1) % 256], 2);

        // new pulse in the grant cycle re-arms the bit
        do_reset();
        dmin = 2; dmax = 2;
        base = obs_n; obase = ovf_cnt;
        evt_req = 4'b1000;
        tick();
        tick();
        evt_req = '0;
        wait_idle(400);
        chk("t4_ovf", ovf_cnt - obase, 0);
        chk("t4_grants", obs_n - base, 2);
        chk("t4_first", obs_ids[base % 256], 3);
        chk("t4_second", obs_ids[(base + 1) % 256], 3);

        // reset mid-handshake
        do_reset();
        dest_en = 1'b0;
        pulse(4'b0010);
        tick();
        chk("t5_in_req", int'(cdc_req_lvl), 1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_req_async", int'(cdc_req_lvl), 0);
        chk("t5_busy_async", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        dest_en = 1'b1;
        repeat (6) tick();
        chk("t5_req_after", int'(cdc_req_lvl), 0);
        chk("t5_busy_after", int'(busy), 0);

        // ack never arrives
        do_reset();
        dest_en = 1'b0;
        dbase = done_n;
        pulse(4'b0001);
        tick();
        chk("t6_in_req", int'(cdc_req_lvl), 1);
`ifdef AQ_DTU_CDC_TIMEOUT_EN
        n = 0;
        while (!cdc_timeout && n < 60) begin
            tick();
            n++;
        end
        chk("t6_timeout_cycles", n, TMO);
        chk("t6_req_dropped", int'(cdc_req_lvl), 0);
        repeat (4) tick();
        chk("t6_idle", int'(busy), 0);
        chk("t6_no_done", done_n - dbase, 0);
        chk("t6_tmo_pulses", tmo_n, 1);
`else
        repeat (40) tick();
        chk("t6_still_req", int'(cdc_req_lvl), 1);
        chk("t6_still_busy", int'(busy), 1);
        chk("t6_no_timeout", tmo_n, 0);
        chk("t6_no_done", done_n - dbase, 0);
`endif
        dest_en = 1'b1;
        do_reset();

        // randomized traffic against the model
        dmin = 1; dmax = 5;
        for (int c = 0; c < 800; c++) begin
            evt_req = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'b0000;
            tick();
        end
        evt_req = '0;
        wait_idle(3000);
        chk("rand_grants_drained", exp_id_q.size(), 0);
        chk("rand_dones_drained", exp_done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
